// File: rtl/pattern_step_gen.sv
// pattern_step_gen: slow-clock and step-enable generator for the
// segment-chase pattern FSM. Two debounced push buttons adjust the speed
// level, a synchronised slide switch pauses the animation.
// Optional build macro: SPEED_WRAP_EN (LEVEL wraps at both ends instead of
// saturating).
module pattern_step_gen #(
  parameter int HALF_BASE   = 2**23,
  parameter int NUM_LEVELS  = 4,
  parameter int RESET_LEVEL = 0,
  parameter int DEBOUNCE    = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_UP,
  input  logic       BTN_DN,
  input  logic       PAUSE,
  output logic       SLOW_CLK,
  output logic       STEP,
  output logic [2:0] LEVEL
);

  localparam int CNT_W = (HALF_BASE > 1) ? $clog2(HALF_BASE) : 1;
  localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [2:0]      MAX_LVL = 3'(NUM_LEVELS - 1);
  localparam logic [2:0]      RST_LVL = 3'(RESET_LEVEL);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  // Index 0 = UP button, 1 = DOWN button, 2 = PAUSE switch.
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;

  logic [DB_W-1:0]  r_db_cnt [2];
  logic [1:0]       r_db_state;
  logic [1:0]       r_press;

  logic [2:0]       r_level;
  logic [2:0]       w_level_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic             r_slow;
  logic             r_step;
  logic [31:0]      w_half_m1;
  logic             w_wrap;
  logic             w_pause;

  // Two-flop synchronisers for the raw asynchronous inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {PAUSE, BTN_DN, BTN_UP};
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debouncer; a press event is a one-cycle pulse registered in
  // the same cycle the stable state goes 0->1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
      r_db_state <= '0;
      r_press    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_db_state[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_state[i] <= r_sync2[i];
          r_db_cnt[i]   <= '0;
          r_press[i]    <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Next speed level from the press events; simultaneous up and down cancel.
  always_comb begin
    w_level_nxt = r_level;
    case (r_press)
      2'b01: begin
`ifdef SPEED_WRAP_EN
        w_level_nxt = (r_level == MAX_LVL) ? 3'd0 : r_level + 3'd1;
`else
        if (r_level != MAX_LVL) w_level_nxt = r_level + 3'd1;
`endif
      end
      2'b10: begin
`ifdef SPEED_WRAP_EN
        w_level_nxt = (r_level == 3'd0) ? MAX_LVL : r_level - 3'd1;
`else
        if (r_level != 3'd0) w_level_nxt = r_level - 3'd1;
`endif
      end
      default: w_level_nxt = r_level;
    endcase
  end

  // Speed level register; updates even while paused.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_level <= RST_LVL;
    end else begin
      r_level <= w_level_nxt;
    end
  end

  // Terminal count uses >= so a speed increase mid-period ends the current
  // half-period on the next cycle instead of running to counter wrap.
  assign w_pause   = r_sync2[2];
  assign w_half_m1 = (32'(HALF_BASE) >> r_level) - 32'd1;
  assign w_wrap    = (32'(r_cnt) >= w_half_m1);

  // Prescaler: toggles SLOW_CLK each half-period, STEP marks the rising edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt  <= '0;
      r_slow <= 1'b0;
      r_step <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (!w_pause) begin
        if (w_wrap) begin
          r_cnt  <= '0;
          r_slow <= ~r_slow;
          r_step <= ~r_slow;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign SLOW_CLK = r_slow;
  assign STEP     = r_step;
  assign LEVEL    = r_level;

endmodule

// File: tb/tb_pattern_step_gen.sv
// Testbench for pattern_step_gen with HALF_BASE=16, NUM_LEVELS=4,
// RESET_LEVEL=0, DEBOUNCE=4. Cycle n = state after the n-th posedge
// following reset release.
module tb_pattern_step_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_UP = 1'b0;
  logic       BTN_DN = 1'b0;
  logic       PAUSE = 1'b0;
  logic       SLOW_CLK;
  logic       STEP;
  logic [2:0] LEVEL;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 CLK = ~CLK;

  pattern_step_gen #(
    .HALF_BASE  (16),
    .NUM_LEVELS (4),
    .RESET_LEVEL(0),
    .DEBOUNCE   (4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .BTN_UP  (BTN_UP),
    .BTN_DN  (BTN_DN),
    .PAUSE   (PAUSE),
    .SLOW_CLK(SLOW_CLK),
    .STEP    (STEP),
    .LEVEL   (LEVEL)
  );

  typedef struct {
    bit         rst;
    int         cyc;
    logic       up;
    logic       dn;
    logic       pause;
    logic       slow;
    logic       step;
    logic [2:0] lvl;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input int c, input logic u, input logic d,
                     input logic p, input logic s, input logic st,
                     input logic [2:0] l, input string n);
    vec_t v;
    v.rst = r; v.cyc = c; v.up = u; v.dn = d; v.pause = p;
    v.slow = s; v.step = st; v.lvl = l; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_out(input string name, input logic s, input logic st, input logic [2:0] l);
    check({name, ".slow"}, {2'b00, SLOW_CLK}, {2'b00, s});
    check({name, ".step"}, {2'b00, STEP}, {2'b00, st});
    check({name, ".level"}, LEVEL, l);
  endtask

  task automatic do_reset();
    RST = 1'b1; BTN_UP = 1'b0; BTN_DN = 1'b0; PAUSE = 1'b0;
    tick();
    tick();
    check_out("reset", 1'b0, 1'b0, 3'd0);
    RST = 1'b0;
    cyc = 0;
  endtask

  task automatic press(input logic u, input logic d);
    BTN_UP = u; BTN_DN = d;
    repeat (8) tick();
    BTN_UP = 1'b0; BTN_DN = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0] exp4, exp5, exp_dn2;
`ifdef SPEED_WRAP_EN
    exp4 = 3'd0; exp5 = 3'd1; exp_dn2 = 3'd3;
`else
    exp4 = 3'd3; exp5 = 3'd3; exp_dn2 = 3'd0;
`endif

    // Free-running at level 0: half-period 16.
    add(1, 15, 0, 0, 0, 0, 0, 0, "t1_c15");
    add(0, 16, 0, 0, 0, 1, 1, 0, "t1_c16");
    add(0, 17, 0, 0, 0, 1, 0, 0, "t1_c17");
    add(0, 31, 0, 0, 0, 1, 0, 0, "t1_c31");
    add(0, 32, 0, 0, 0, 0, 0, 0, "t1_c32");
    add(0, 47, 0, 0, 0, 0, 0, 0, "t1_c47");
    add(0, 48, 0, 0, 0, 1, 1, 0, "t1_c48");
    add(0, 49, 0, 0, 0, 1, 0, 0, "t1_c49");
    add(0, 64, 0, 0, 0, 0, 0, 0, "t1_c64");
    add(0, 80, 0, 0, 0, 1, 1, 0, "t1_c80");
    add(0, 81, 0, 0, 0, 1, 0, 0, "t1_c81");
    // Glitch rejected, then a real press lands 7 edges after first sample.
    add(1,  2, 1, 0, 0, 0, 0, 0, "t2_glitch");
    add(0, 12, 0, 0, 0, 0, 0, 0, "t2_noevt");
    add(0, 18, 1, 0, 0, 1, 0, 0, "t2_c18");
    add(0, 19, 1, 0, 0, 1, 0, 1, "t2_c19");
    add(0, 22, 1, 0, 0, 1, 0, 1, "t2_c22");
    add(0, 23, 0, 0, 0, 1, 0, 1, "t2_c23");
    add(0, 24, 0, 0, 0, 0, 0, 1, "t2_c24");
    add(0, 31, 0, 0, 0, 0, 0, 1, "t2_c31");
    add(0, 32, 0, 0, 0, 1, 1, 1, "t2_c32");
    add(0, 33, 0, 0, 0, 1, 0, 1, "t2_c33");
    add(0, 40, 0, 0, 0, 0, 0, 1, "t2_c40");
    add(0, 48, 0, 0, 0, 1, 1, 1, "t2_c48");
    // Speed-up with cnt already past the new terminal count.
    add(1,  5, 0, 0, 0, 0, 0, 0, "t4_c5");
    add(0, 11, 1, 0, 0, 0, 0, 0, "t4_c11");
    add(0, 12, 1, 0, 0, 0, 0, 1, "t4_c12");
    add(0, 13, 1, 0, 0, 1, 1, 1, "t4_c13");
    add(0, 14, 0, 0, 0, 1, 0, 1, "t4_c14");
    add(0, 20, 0, 0, 0, 1, 0, 1, "t4_c20");
    add(0, 21, 0, 0, 0, 0, 0, 1, "t4_c21");
    add(0, 28, 0, 0, 0, 0, 0, 1, "t4_c28");
    add(0, 29, 0, 0, 0, 1, 1, 1, "t4_c29");
    // Pause for 50 cycles mid-period; count resumes where it stopped.
    add(1,  5, 0, 0, 0, 0, 0, 0, "t5_c5");
    add(0, 30, 0, 0, 1, 0, 0, 0, "t5_c30");
    add(0, 55, 0, 0, 1, 0, 0, 0, "t5_c55");
    add(0, 65, 0, 0, 0, 0, 0, 0, "t5_c65");
    add(0, 66, 0, 0, 0, 1, 1, 0, "t5_c66");
    add(0, 67, 0, 0, 0, 1, 0, 0, "t5_c67");

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      BTN_UP = vecs[i].up; BTN_DN = vecs[i].dn; PAUSE = vecs[i].pause;
      while (cyc < vecs[i].cyc) tick();
      check_out(vecs[i].name, vecs[i].slow, vecs[i].step, vecs[i].lvl);
    end

    // Five presses: saturation (or wrap) at the top level.
    do_reset();
    press(1, 0); check("t3_p1", LEVEL, 3'd1);
    press(1, 0); check("t3_p2", LEVEL, 3'd2);
    press(1, 0); check("t3_p3", LEVEL, 3'd3);
    n = 0;
    while (STEP !== 1'b1 && n < 20) begin tick(); n++; end
    check("t3_step_seen", {2'b00, STEP}, 3'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("t3_l3_slow%0d", k), {2'b00, SLOW_CLK}, {2'b00, ((k % 4) == 0) || ((k % 4) == 1)});
      check($sformatf("t3_l3_step%0d", k), {2'b00, STEP}, {2'b00, (k % 4) == 0});
    end
    press(1, 0); check("t3_p4", LEVEL, exp4);
    press(1, 0); check("t3_p5", LEVEL, exp5);

    // Simultaneous up+down cancels; down saturates (or wraps) at 0.
    do_reset();
    press(1, 0); check("t5_up", LEVEL, 3'd1);
    press(1, 1); check("t5_both", LEVEL, 3'd1);
    press(0, 1); check("t5_dn1", LEVEL, 3'd0);
    press(0, 1); check("t5_dn2", LEVEL, exp_dn2);

    // Reset mid-period and mid-debounce.
    do_reset();
    press(1, 0);
    press(1, 0); check("t6_lvl2", LEVEL, 3'd2);
    n = 0;
    while (SLOW_CLK !== 1'b1 && n < 20) begin tick(); n++; end
    check("t6_slow_hi", {2'b00, SLOW_CLK}, 3'd1);
    BTN_UP = 1'b1;
    repeat (3) tick();
    RST = 1'b1; BTN_UP = 1'b0;
    tick();
    check_out("t6_rst", 1'b0, 1'b0, 3'd0);
    RST = 1'b0;
    repeat (20) tick();
    check("t6_no_evt", LEVEL, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
